cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the two common data buses (cdb1, cdb2) between functional-unit result producers (ALUs, LSU, branch unit).
- Up to two winners per cycle, chosen round-robin with a starvation override.
- Broadcasts the winners' tag/value on registered CDB outputs one cycle later.
- Those CDB outputs feed the dispatch scheduler, reservation stations, ROB and map table. Tag 0 means "no broadcast".

Parameters:
- N_REQ, 4, number of result producers (2..8).
- TAG_W, 32, tag width; ROB tags are 1-based, 0 = none.
- DATA_W, 32, result value width.
- STARVE_LIMIT, 3, consecutive lost cycles after which a requester is forced onto cdb1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush (mispredict); synchronous.
- req_valid  in  N_REQ  per-requester result valid; held until granted.
- req_tag  in  N_REQ*TAG_W  per-requester ROB tag, packed, requester 0 in LSBs.
- req_value  in  N_REQ*DATA_W  per-requester result value, packed.
- req_grant  out  N_REQ  combinational one-hot-or-two-hot grant, same cycle as request.
- cdb1_tag  out  TAG_W  registered broadcast tag, slot 1.
- cdb1_value  out  DATA_W  registered broadcast value, slot 1.
- cdb2_tag  out  TAG_W  registered broadcast tag, slot 2.
- cdb2_value  out  DATA_W  registered broadcast value, slot 2.
- err_zero_tag  out  1  registered pulse: a valid request carried tag 0.

Behaviour:
- Reset:
  - cdb1/cdb2 tag and value = 0; err_zero_tag = 0.
  - rr_ptr = 0; all wait counters = 0.
  - req_grant = 0 while reset is high.
- Eligibility:
  - Requester i is eligible when req_valid[i] = 1 and req_tag[i] != 0.
  - A valid request with tag 0 is never granted. It sets err_zero_tag = 1 for the next cycle.
- Handshake:
  - A request is consumed in a cycle where req_valid[i] and req_grant[i] are both 1.
  - A requester must hold tag/value stable until granted.
  - The arbiter never grants an invalid requester.
- Selection, each cycle when not in flush or reset:
  - Starvation override: if any eligible requester has wait_cnt >= STARVE_LIMIT, the lowest-index such requester is winner A. Otherwise winner A is the first eligible requester scanning i = rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Winner B is the next eligible requester after A in round-robin order from rr_ptr, excluding A.
  - Zero, one or two grants per cycle.
- Slot mapping: winner A goes to cdb1 and winner B to cdb2. A slot with no winner broadcasts tag 0, value 0.
- Latency: CDB outputs register the winners' tag/value at the clock edge ending the grant cycle. There is exactly 1 cycle from grant to broadcast. There is no backpressure from the CDB.
- rr_ptr update:
  - If there are any grants, rr_ptr <= (highest-priority-order position of the last granted requester + 1) mod N_REQ, i.e. one past winner B (or past A if only one grant).
  - With no grants, rr_ptr is unchanged.
  - Wrap-around: rr_ptr = N_REQ-1 plus 1 gives 0.
- Wait counters:
  - wait_cnt[i] increments (saturating at STARVE_LIMIT) when requester i is eligible and not granted.
  - It clears on grant or when req_valid[i] = 0.
- Flush:
  - req_grant = 0 in the flush cycle.
  - The next edge clears the CDB outputs to 0, resets wait counters to 0 and sets rr_ptr = 0.
  - Requests present during flush are not consumed; requesters drop them themselves.
- Reset overrides flush. Reset mid-broadcast: outputs are 0 after the reset edge, and any granted-but-unbroadcast results are lost.
- Duplicate tags in one cycle (should not happen) are both broadcast as-is; no deduplication.

Optional Feature:
- CDB_AGE_PRIORITY_EN: adds input rob_head (TAG_W).
  - When defined, round-robin ordering is replaced by age. Eligible requesters are ranked by (req_tag - rob_head) mod ROB capacity (2^TAG_W), smallest first. Ties go to the lower index.
  - The starvation override still applies first. rr_ptr is retained but unused.
- Without the macro: pure round-robin as above, and there is no rob_head port.

Test Plan:
- Reset, then all req_valid = 0 for 3 cycles -> req_grant = 0000; cdb1_tag = cdb2_tag = 0 every cycle.
- rr_ptr = 0; req_valid = 1011, tags 5/6/x/8, all held valid -> cycle0 grant = 0011 (cdb1 = 5, cdb2 = 6 next cycle), rr_ptr = 2.
  - Cycle1 grant = 1001 (r3 first, cdb1 = 8; r0 wraps, cdb2 = 5), rr_ptr = 1.
- Requester 3 valid continuously with tag 9 while r0/r1/r2 re-request every cycle -> r3 granted on cdb1 no later than its 4th waiting cycle (STARVE_LIMIT = 3).
- flush = 1 with 3 valid requests -> req_grant = 0000 that cycle; next cycle cdb tags = 0 and rr_ptr = 0.
  - The following cycle r0 and r1 are granted.
- req_valid[2] = 1, req_tag[2] = 0 -> no grant to r2; err_zero_tag = 1 for one cycle; other requesters are unaffected.
- With CDB_AGE_PRIORITY_EN, rob_head = 10, tags r0 = 14, r1 = 11, r2 = 12 -> grants r1 (cdb1 = 11) and r2 (cdb2 = 12); r0 is granted next cycle.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Two-slot common data bus arbiter: round-robin selection with a starvation override.
// Build macro CDB_AGE_PRIORITY_EN ranks requesters by ROB age instead (adds rob_head).
module cdb_arbiter #(
    parameter int N_REQ        = 4,
    parameter int TAG_W        = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0] req_value,
`ifdef CDB_AGE_PRIORITY_EN
    input  logic [TAG_W-1:0]        rob_head,
`endif
    output logic [N_REQ-1:0]        req_grant,
    output logic [TAG_W-1:0]        cdb1_tag,
    output logic [DATA_W-1:0]       cdb1_value,
    output logic [TAG_W-1:0]        cdb2_tag,
    output logic [DATA_W-1:0]       cdb2_value,
    output logic                    err_zero_tag
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
`ifdef CDB_AGE_PRIORITY_EN
    localparam int KEY_W = TAG_W;
`else
    localparam int KEY_W = PTR_W;
`endif

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  wait_cnt_q [N_REQ];
    logic [CNT_W-1:0]  wait_cnt_d [N_REQ];
    logic [TAG_W-1:0]  cdb1_tag_q, cdb1_tag_d, cdb2_tag_q, cdb2_tag_d;
    logic [DATA_W-1:0] cdb1_value_q, cdb1_value_d, cdb2_value_q, cdb2_value_d;
    logic              err_zero_tag_q, err_zero_tag_d;

    logic [N_REQ-1:0]  elig, zero_req, starved, win_a, win_b, win_last;
    logic [KEY_W-1:0]  key [N_REQ];
    logic [KEY_W-1:0]  best_a, best_b;
    logic              found_a, found_b;

    // Smaller key = higher priority: distance from rr_ptr, or age relative to rob_head.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            zero_req[i] = req_valid[i] && (req_tag[i*TAG_W +: TAG_W] == '0);
            elig[i]     = req_valid[i] && !zero_req[i];
            starved[i]  = elig[i] && (wait_cnt_q[i] >= CNT_W'(STARVE_LIMIT));
`ifdef CDB_AGE_PRIORITY_EN
            key[i]      = req_tag[i*TAG_W +: TAG_W] - rob_head;
`else
            key[i]      = KEY_W'((i + N_REQ - int'(rr_ptr_q)) % N_REQ);
`endif
        end
    end

    always_comb begin
        found_a = 1'b0;
        best_a  = '0;
        win_a   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (elig[i] && (!found_a || key[i] < best_a)) begin
                found_a  = 1'b1;
                best_a   = key[i];
                win_a    = '0;
                win_a[i] = 1'b1;
            end
        end
        if (|starved) begin
            win_a = starved & (~starved + N_REQ'(1));
        end

        found_b = 1'b0;
        best_b  = '0;
        win_b   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (elig[i] && !win_a[i] && (!found_b || key[i] < best_b)) begin
                found_b  = 1'b1;
                best_b   = key[i];
                win_b    = '0;
                win_b[i] = 1'b1;
            end
        end

        if (reset || flush) begin
            win_a = '0;
            win_b = '0;
        end
        win_last  = (|win_b) ? win_b : win_a;
        req_grant = win_a | win_b;
    end

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        cdb1_tag_d     = '0;
        cdb1_value_d   = '0;
        cdb2_tag_d     = '0;
        cdb2_value_d   = '0;
        err_zero_tag_d = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            wait_cnt_d[i] = '0;
        end

        if (flush) begin
            rr_ptr_d = '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (win_a[i]) begin
                    cdb1_tag_d   = req_tag[i*TAG_W +: TAG_W];
                    cdb1_value_d = req_value[i*DATA_W +: DATA_W];
                end
                if (win_b[i]) begin
                    cdb2_tag_d   = req_tag[i*TAG_W +: TAG_W];
                    cdb2_value_d = req_value[i*DATA_W +: DATA_W];
                end
                if (win_last[i]) begin
                    rr_ptr_d = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
                end
                if (elig[i] && !req_grant[i]) begin
                    if (wait_cnt_q[i] < CNT_W'(STARVE_LIMIT)) begin
                        wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
                    end else begin
                        wait_cnt_d[i] = wait_cnt_q[i];
                    end
                end
            end
            err_zero_tag_d = |zero_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q       <= '0;
            cdb1_tag_q     <= '0;
            cdb1_value_q   <= '0;
            cdb2_tag_q     <= '0;
            cdb2_value_q   <= '0;
            err_zero_tag_q <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            cdb1_tag_q     <= cdb1_tag_d;
            cdb1_value_q   <= cdb1_value_d;
            cdb2_tag_q     <= cdb2_tag_d;
            cdb2_value_q   <= cdb2_value_d;
            err_zero_tag_q <= err_zero_tag_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    assign cdb1_tag     = cdb1_tag_q;
    assign cdb1_value   = cdb1_value_q;
    assign cdb2_tag     = cdb2_tag_q;
    assign cdb2_value   = cdb2_value_q;
    assign err_zero_tag = err_zero_tag_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios followed by randomized requesters.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int TW = 32;
    localparam int DW = 32;
    localparam int SL = 3;

    logic          clk = 1'b0;
    logic          reset, flush;
    logic [N-1:0]  req_valid, req_grant;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_value;
    logic [TW-1:0] cdb1_tag, cdb2_tag;
    logic [DW-1:0] cdb1_value, cdb2_value;
    logic          err_zero_tag;
`ifdef CDB_AGE_PRIORITY_EN
    logic [TW-1:0] rob_head;
`endif

    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value),
`ifdef CDB_AGE_PRIORITY_EN
        .rob_head(rob_head),
`endif
        .req_grant(req_grant),
        .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
        .cdb2_tag(cdb2_tag), .cdb2_value(cdb2_value),
        .err_zero_tag(err_zero_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] t1;
        logic [DW-1:0] v1;
        logic [TW-1:0] t2;
        logic [DW-1:0] v2;
        logic          err;
    } exp_t;

    exp_t         exp_q [$];
    exp_t         mon_e;
    int           checks = 0;
    int           passes = 0;
    int           m_rr;
    int           m_wait [N];
    logic [N-1:0] exp_grant;
    logic         pend [N];
    logic [TW-1:0] ptag [N];
    logic [DW-1:0] pval [N];
    logic         r3_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [TW-1:0] tag_of(input int i);
        return req_tag[i*TW +: TW];
    endfunction

    function automatic logic [DW-1:0] val_of(input int i);
        return req_value[i*DW +: DW];
    endfunction

    task automatic drive_pending();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pend[i];
            req_tag[i*TW +: TW] = ptag[i];
            req_value[i*DW +: DW] = pval[i];
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
        pend[i] = v;
        ptag[i] = t;
        pval[i] = d;
    endtask

    // Reference model: evaluates the current inputs, checks the grant, queues the broadcast.
    task automatic tick();
        logic [N-1:0] eg, g;
        logic         zt;
        int           a, b, idx;
        exp_t         e;
        #1;
        a = -1; b = -1; g = '0; zt = 1'b0; e = '0;
        for (int i = 0; i < N; i++) begin
            eg[i] = req_valid[i] && (tag_of(i) != 0);
            if (req_valid[i] && tag_of(i) == 0) zt = 1'b1;
        end
        if (reset || flush) begin
            m_rr = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) if (a < 0 && eg[i] && m_wait[i] >= SL) a = i;
`ifdef CDB_AGE_PRIORITY_EN
            if (a < 0)
                for (int i = 0; i < N; i++)
                    if (eg[i] && (a < 0 || (tag_of(i) - rob_head) < (tag_of(a) - rob_head))) a = i;
            for (int i = 0; i < N; i++)
                if (eg[i] && i != a && (b < 0 || (tag_of(i) - rob_head) < (tag_of(b) - rob_head))) b = i;
`else
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (a < 0 && eg[idx]) a = idx;
            end
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (b < 0 && eg[idx] && idx != a) b = idx;
            end
`endif
            if (a >= 0) begin g[a] = 1'b1; e.t1 = tag_of(a); e.v1 = val_of(a); end
            if (b >= 0) begin g[b] = 1'b1; e.t2 = tag_of(b); e.v2 = val_of(b); end
            if (b >= 0) m_rr = (b + 1) % N;
            else if (a >= 0) m_rr = (a + 1) % N;
            for (int i = 0; i < N; i++)
                m_wait[i] = (eg[i] && !g[i]) ? ((m_wait[i] < SL) ? m_wait[i] + 1 : SL) : 0;
            e.err = zt;
        end
        check("req_grant", req_grant, g);
        exp_grant = g;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("cdb1_tag", cdb1_tag, mon_e.t1);
                check("cdb1_value", cdb1_value, mon_e.v1);
                check("cdb2_tag", cdb2_tag, mon_e.t2);
                check("cdb2_value", cdb2_value, mon_e.v2);
                check("err_zero_tag", err_zero_tag, mon_e.err);
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        req_valid = '0; req_tag = '0; req_value = '0;
`ifdef CDB_AGE_PRIORITY_EN
        rob_head = '0;
`endif
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
        tick(); tick();
        reset = 1'b0;
        repeat (3) tick();

        // Round-robin from rr_ptr = 0 with requests held valid
        set_req(0, 1'b1, 5, 32'h105);
        set_req(1, 1'b1, 6, 32'h106);
        set_req(3, 1'b1, 8, 32'h108);
        drive_pending();
`ifndef CDB_AGE_PRIORITY_EN
        #1 check("rr_cycle0_grant", req_grant, 4'b0011);
`endif
        tick();
`ifndef CDB_AGE_PRIORITY_EN
        #1 check("rr_cycle1_grant", req_grant, 4'b1001);
`endif
        tick();

        // Requester 3 held valid while the others keep requesting
        set_req(0, 1'b1, 1, 32'h201);
        set_req(1, 1'b1, 2, 32'h202);
        set_req(2, 1'b1, 3, 32'h203);
        set_req(3, 1'b1, 9, 32'h209);
        drive_pending();
        r3_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1 if (req_grant[3]) r3_seen = 1'b1;
            tick();
        end
        check("r3_granted_within_4", r3_seen, 1'b1);

        // Flush suppresses grants and resets rr_ptr
        set_req(0, 1'b1, 21, 32'h321);
        set_req(1, 1'b1, 22, 32'h322);
        set_req(2, 1'b1, 23, 32'h323);
        set_req(3, 1'b0, 0, 0);
        drive_pending();
        flush = 1'b1;
        #1 check("flush_grant", req_grant, 4'b0000);
        tick();
        flush = 1'b0;
        #1 check("post_flush_grant", req_grant, 4'b0011);
        tick();

        // Zero-tag request
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
        set_req(0, 1'b1, 31, 32'h431);
        set_req(1, 1'b1, 32, 32'h432);
        set_req(2, 1'b1, 0, 32'h400);
        drive_pending();
        #1 check("zero_tag_not_granted", req_grant[2], 1'b0);
        tick();
        check("err_zero_tag_set", err_zero_tag, 1'b1);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
        drive_pending();
        tick();
        check("err_zero_tag_clear", err_zero_tag, 1'b0);

`ifdef CDB_AGE_PRIORITY_EN
        rob_head = 10;
        set_req(0, 1'b1, 14, 32'h514);
        set_req(1, 1'b1, 11, 32'h511);
        set_req(2, 1'b1, 12, 32'h512);
        drive_pending();
        #1 check("age_grant0", req_grant, 4'b0110);
        tick();
        set_req(1, 1'b0, 0, 0);
        set_req(2, 1'b0, 0, 0);
        drive_pending();
        #1 check("age_grant1", req_grant, 4'b0001);
        tick();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
`endif

        // Randomized requesters honouring the hold-until-granted handshake
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (exp_grant[i] || flush || (pend[i] && ptag[i] == 0)) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 99) < 55) begin
                    pend[i] = 1'b1;
                    ptag[i] = ($urandom_range(0, 19) == 0) ? '0 : TW'($urandom_range(1, 24));
                    pval[i] = $urandom;
                end
            end
            flush = ($urandom_range(0, 99) < 4);
`ifdef CDB_AGE_PRIORITY_EN
            rob_head = TW'($urandom_range(0, 30));
`endif
            drive_pending();
            tick();
        end

        flush = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
        drive_pending();
        repeat (3) tick();
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
